uvma_axil_slv_rsp: RTL

Synthesizable AXI4-Lite slave responder that terminates the master side of uvma_axil_if with a small word-addressed register memory. It serves as the agent's self-test DUT and as a stand-in target in block benches. Write and read channels are independent. The write path accepts AW and W in either order, and the read path returns data after a fixed, configurable latency.

---
 rtl/uvma_axil_rsp_pkg.sv | 32 +++
 rtl/uvma_axil_rsp_mem.sv | 34 +++
 rtl/uvma_axil_slv_rsp.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uvma_axil_rsp_pkg.sv
// Shared types and width helpers for the AXI4-Lite slave responder.
package uvma_axil_rsp_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } uvma_axil_resp_enum;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  function automatic int off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int num_words);
    return $clog2(num_words);
  endfunction

endpackage

// File: rtl/uvma_axil_rsp_mem.sv
// Word memory with async clear, byte-strobed write port and combinational read port.
module uvma_axil_rsp_mem
  import uvma_axil_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             we,
  input  logic [idx_width(NUM_WORDS)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic [idx_width(NUM_WORDS)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uvma_axil_slv_rsp.sv
// AXI4-Lite slave responder: independent write (AW/W any order) and read (fixed latency)
// channels over a small register memory; out-of-range accesses answer SLVERR.
module uvma_axil_slv_rsp
  import uvma_axil_rsp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int OFF_W = off_width(DATA_WIDTH);
  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam int SPAN  = OFF_W + IDX_W;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  // Any address bit above the memory span set means out of range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> SPAN) == '0;
  endfunction

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // ---------------- write channel ----------------
  w_state_e              w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic                  aw_hs, w_hs, wr_fire, mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_comb begin
    w_state_n = w_state;
    wr_fire   = 1'b0;
    wr_addr   = awaddr;
    wr_data   = wdata;
    wr_strb   = wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_n = W_RESP;
          wr_fire   = 1'b1;
        end else if (aw_hs) begin
          w_state_n = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_n = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        wr_addr = aw_addr_q;
        if (w_hs) begin
          w_state_n = W_RESP;
          wr_fire   = 1'b1;
        end
      end
      W_HAVE_W: begin
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        if (aw_hs) begin
          w_state_n = W_RESP;
          wr_fire   = 1'b1;
        end
      end
      W_RESP: if (bvalid && bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  assign mem_we = wr_fire && in_range(wr_addr);

  // Ready/valid are registered from the next state so they reset low and rise one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      w_state <= w_state_n;
      if (w_state == W_IDLE && aw_hs) aw_addr_q <= awaddr;
      if (w_state == W_IDLE && w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      awready <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_W);
      wready  <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_AW);
      bvalid  <= (w_state_n == W_RESP);
      if (wr_fire) bresp <= in_range(wr_addr) ? OKAY : SLVERR;
    end
  end

  // ---------------- memory ----------------
  logic [DATA_WIDTH-1:0] mem_rdata;

  uvma_axil_rsp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (wr_addr[OFF_W +: IDX_W]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (araddr[OFF_W +: IDX_W]),
    .rdata (mem_rdata)
  );

  // ---------------- read channel ----------------
  r_state_e              r_state, r_state_n;
  logic [CNT_W-1:0]      lat_cnt;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic [1:0]            rd_resp_q;
  logic                  ar_hs;

  assign ar_hs = arvalid & arready;

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_n = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
      R_WAIT: if (lat_cnt == CNT_W'(1)) r_state_n = R_RESP;
      R_RESP: if (rvalid && rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Capture on the AR edge reads the array before any same-edge write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      lat_cnt   <= '0;
      rd_buf    <= '0;
      rd_resp_q <= OKAY;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
    end else begin
      r_state <= r_state_n;
      if (r_state == R_IDLE && ar_hs) begin
        lat_cnt   <= CNT_W'(RD_LATENCY - 1);
        rd_buf    <= in_range(araddr) ? mem_rdata : '0;
        rd_resp_q <= in_range(araddr) ? OKAY : SLVERR;
      end else if (r_state == R_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      arready <= (r_state_n == R_IDLE);
      rvalid  <= (r_state_n == R_RESP);
    end
  end

  assign rdata = rvalid ? rd_buf : '0;
  assign rresp = rvalid ? rd_resp_q : 2'b00;

endmodule
